isqrt_pipe_arbiter: RTL and testbench

Shares one pipelined isqrt unit (32-bit in, 16-bit out, one input per cycle, in-order results, arbitrary fixed latency) among N_REQ independent requesters, e.g. several formula FSMs or pipelines. Accepted requests are granted round-robin and issued through a registered isqrt input stage. Each request's requester index is tracked in a tag FIFO, and each result is routed back to its originator. An in-flight credit limit keeps the tag FIFO from overflowing.

---
 rtl/isqrt_arb_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/isqrt_pipe_arbiter.sv | 121 ++++++++++++
 tb/tb_isqrt_pipe_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/isqrt_arb_pkg.sv
// Shared widths and helpers for the isqrt arbiter slice.
package isqrt_arb_pkg;

    localparam int unsigned ISQRT_X_W = 32;
    localparam int unsigned ISQRT_Y_W = 16;

    // Width of an index into n items, never less than one bit.
    function automatic int unsigned tag_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at ptr, ptr moves past the winner.
module rr_arbiter
    import isqrt_arb_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = tag_w(N);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] idx, gnt_idx;
    logic          found;

    // First requester at or after ptr wins; ptr advances only on a grant.
    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        idx     = ptr_q;
        gnt_idx = ptr_q;
        for (int unsigned off = 0; off < N; off++) begin
            idx = PW'((32'(ptr_q) + off) % N);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + PW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/isqrt_pipe_arbiter.sv
// Shares one in-order pipelined isqrt unit among N_REQ requesters. A tag FIFO
// remembers who issued each operand so results can be steered back.
module isqrt_pipe_arbiter
    import isqrt_arb_pkg::*;
#(
    parameter int unsigned N_REQ        = 3,
    parameter int unsigned MAX_INFLIGHT = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req_vld,
    input  logic [N_REQ*ISQRT_X_W-1:0]      req_x,
    output logic [N_REQ-1:0]                req_rdy,
    output logic [N_REQ-1:0]                rsp_vld,
    output logic [ISQRT_Y_W-1:0]            rsp_y,
    output logic                            isqrt_x_vld,
    output logic [ISQRT_X_W-1:0]            isqrt_x,
    input  logic                            isqrt_y_vld,
    input  logic [ISQRT_Y_W-1:0]            isqrt_y,
    output logic [$clog2(MAX_INFLIGHT):0]   inflight,
    output logic                            err_unexpected
);

    localparam int unsigned TAG_W = tag_w(N_REQ);
    localparam int unsigned AW    = $clog2(MAX_INFLIGHT);
    localparam int unsigned CNT_W = AW + 1;

    logic                 issue_en, acc, pop;
    logic                 fifo_empty, fifo_full;
    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    logic [TAG_W-1:0]     tag_mem [MAX_INFLIGHT];
    logic [TAG_W-1:0]     acc_tag, pop_tag;
    logic [ISQRT_X_W-1:0] acc_x;

    logic                 isqrt_x_vld_q;
    logic [ISQRT_X_W-1:0] isqrt_x_q;
    logic [N_REQ-1:0]     rsp_vld_q;
    logic [ISQRT_Y_W-1:0] rsp_y_q;
    logic [CNT_W-1:0]     inflight_q;
    logic                 err_q;

    // Extra wrap bit distinguishes full from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Credit check ignores a same-cycle pop so no path runs from isqrt_y_vld to req_rdy.
    assign issue_en = !rst && !fifo_full && (inflight_q < CNT_W'(MAX_INFLIGHT));

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_vld),
        .en  (issue_en),
        .gnt (req_rdy)
    );

    assign acc     = |req_rdy;
    assign pop     = isqrt_y_vld && !fifo_empty;
    assign pop_tag = tag_mem[rd_ptr_q[AW-1:0]];

    // Encode the one-hot grant into a tag and select the winner's operand.
    always_comb begin
        acc_tag = '0;
        acc_x   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (req_rdy[i]) begin
                acc_tag = acc_tag | TAG_W'(i);
                acc_x   = acc_x | req_x[i*ISQRT_X_W +: ISQRT_X_W];
            end
        end
    end

    // Tag storage; contents are meaningless while the pointers say empty.
    always_ff @(posedge clk) begin
        if (acc) begin
            tag_mem[wr_ptr_q[AW-1:0]] <= acc_tag;
        end
    end

    // Issue stage, FIFO pointers, credit counter, result routing and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            isqrt_x_vld_q <= 1'b0;
            isqrt_x_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rsp_vld_q     <= '0;
            rsp_y_q       <= '0;
            inflight_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            isqrt_x_vld_q <= acc;
            if (acc) begin
                isqrt_x_q <= acc_x;
            end
            wr_ptr_q  <= wr_ptr_q + {{AW{1'b0}}, acc};
            rd_ptr_q  <= rd_ptr_q + {{AW{1'b0}}, pop};
            rsp_vld_q <= pop ? (N_REQ'(1) << pop_tag) : '0;
            if (pop) begin
                rsp_y_q <= isqrt_y;
            end
            if (acc && !pop) begin
                inflight_q <= inflight_q + CNT_W'(1);
            end else if (!acc && pop) begin
                inflight_q <= inflight_q - CNT_W'(1);
            end
            err_q <= err_q | (isqrt_y_vld && fifo_empty);
        end
    end

    assign isqrt_x_vld    = isqrt_x_vld_q;
    assign isqrt_x        = isqrt_x_q;
    assign rsp_vld        = rsp_vld_q;
    assign rsp_y          = rsp_y_q;
    assign inflight       = inflight_q;
    assign err_unexpected = err_q;

endmodule

// File: tb/tb_isqrt_pipe_arbiter.sv
// Bench for isqrt_pipe_arbiter: two instances (MAX_INFLIGHT 16 and 2), each
// driving a 4-stage isqrt model, with scoreboards checking routing, data and latency.
module tb_isqrt_pipe_arbiter;

    localparam int NR = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference integer square root, bit by bit from the top.
    function automatic logic [15:0] isqrt_ref(input logic [31:0] x);
        logic [15:0] r;
        logic [15:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'(1) << b);
            if ({16'b0, t} * {16'b0, t} <= x) r = t;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // DUT 1 (MAX_INFLIGHT = 16)
    logic [NR-1:0]    req_vld, req_rdy, rsp_vld;
    logic [NR*32-1:0] req_x;
    logic [15:0]      rsp_y, iy, inj_y;
    logic             ix_vld, iy_vld, err, inj_vld;
    logic [31:0]      ix;
    logic [4:0]       infl;

    isqrt_pipe_arbiter #(.N_REQ(NR), .MAX_INFLIGHT(16)) dut (
        .clk (clk), .rst (rst), .req_vld (req_vld), .req_x (req_x), .req_rdy (req_rdy),
        .rsp_vld (rsp_vld), .rsp_y (rsp_y), .isqrt_x_vld (ix_vld), .isqrt_x (ix),
        .isqrt_y_vld (iy_vld), .isqrt_y (iy), .inflight (infl), .err_unexpected (err)
    );

    // DUT 2 (MAX_INFLIGHT = 2)
    logic [NR-1:0]    req_vld2, req_rdy2, rsp_vld2;
    logic [NR*32-1:0] req_x2;
    logic [15:0]      rsp_y2, iy2;
    logic             ix_vld2, iy_vld2, err2;
    logic [31:0]      ix2;
    logic [1:0]       infl2;

    isqrt_pipe_arbiter #(.N_REQ(NR), .MAX_INFLIGHT(2)) dut2 (
        .clk (clk), .rst (rst), .req_vld (req_vld2), .req_x (req_x2), .req_rdy (req_rdy2),
        .rsp_vld (rsp_vld2), .rsp_y (rsp_y2), .isqrt_x_vld (ix_vld2), .isqrt_x (ix2),
        .isqrt_y_vld (iy_vld2), .isqrt_y (iy2), .inflight (infl2), .err_unexpected (err2)
    );

    // isqrt unit models, latency 4, reset from the same rst.
    logic [3:0]  pv1, pv2;
    logic [15:0] py1 [4];
    logic [15:0] py2 [4];
    always @(posedge clk) begin
        if (rst) begin
            pv1 <= '0;
            pv2 <= '0;
        end else begin
            pv1 <= {pv1[2:0], ix_vld};
            pv2 <= {pv2[2:0], ix_vld2};
        end
        py1[0] <= isqrt_ref(ix);
        py2[0] <= isqrt_ref(ix2);
        for (int k = 1; k < 4; k++) begin
            py1[k] <= py1[k-1];
            py2[k] <= py2[k-1];
        end
    end
    assign iy_vld  = pv1[3] | inj_vld;
    assign iy      = inj_vld ? inj_y : py1[3];
    assign iy_vld2 = pv2[3];
    assign iy2     = py2[3];

    typedef struct {
        int          idx;
        logic [15:0] y;
        int          cyc;
    } ent_t;
    ent_t sb1[$];
    ent_t sb2[$];

    // Scoreboard for DUT 1.
    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            sb1.delete();
        end else begin
            if (rsp_vld != '0) begin
                if (sb1.size() == 0) begin
                    check("rsp1_unexpected", 64'(rsp_vld), 64'(0));
                end else begin
                    e = sb1.pop_front();
                    check("rsp1_dest", 64'(rsp_vld), 64'(3'(1) << e.idx));
                    check("rsp1_data", 64'(rsp_y), 64'(e.y));
                    check("rsp1_latency", 64'(cyc - e.cyc), 64'(6));
                end
            end
            for (int i = 0; i < NR; i++)
                if (req_vld[i] && req_rdy[i])
                    sb1.push_back('{i, isqrt_ref(req_x[i*32 +: 32]), cyc});
        end
    end

    // Scoreboard for DUT 2.
    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            sb2.delete();
        end else begin
            if (rsp_vld2 != '0) begin
                if (sb2.size() == 0) begin
                    check("rsp2_unexpected", 64'(rsp_vld2), 64'(0));
                end else begin
                    e = sb2.pop_front();
                    check("rsp2_dest", 64'(rsp_vld2), 64'(3'(1) << e.idx));
                    check("rsp2_data", 64'(rsp_y2), 64'(e.y));
                    check("rsp2_latency", 64'(cyc - e.cyc), 64'(6));
                end
            end
            for (int i = 0; i < NR; i++)
                if (req_vld2[i] && req_rdy2[i])
                    sb2.push_back('{i, isqrt_ref(req_x2[i*32 +: 32]), cyc});
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_xvld"}, 64'(ix_vld), 64'(0));
        check({tag, "_x"}, 64'(ix), 64'(0));
        check({tag, "_rspvld"}, 64'(rsp_vld), 64'(0));
        check({tag, "_rspy"}, 64'(rsp_y), 64'(0));
        check({tag, "_infl"}, 64'(infl), 64'(0));
        check({tag, "_err"}, 64'(err), 64'(0));
    endtask

    initial begin
        logic [31:0] mid_x [5];
        logic [31:0] post_x [3];
        logic [NR-1:0] acc;
        int acc_cnt;
        int nxt;

        mid_x  = '{32'd1000, 32'd2000, 32'd3000, 32'd4000, 32'd5000};
        post_x = '{32'd0, 32'hFFFF_FFFF, 32'd99};
        rst = 1'b1; req_vld = '0; req_x = '0; inj_vld = 1'b0; inj_y = '0;
        req_vld2 = '0; req_x2 = '0;

        // Reset: no grants while rst is high, then reset values.
        @(posedge clk); #1; req_vld = 3'b111; req_vld2 = 3'b111;
        @(negedge clk);
        check("rdy_in_reset", 64'(req_rdy), 64'(0));
        check("rdy2_in_reset", 64'(req_rdy2), 64'(0));
        @(posedge clk); #1; req_vld = '0; req_vld2 = '0; rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
        check("reset_infl2", 64'(infl2), 64'(0));

        // Single request from requester 1.
        @(posedge clk); #1; req_x[63:32] = 32'd144; req_vld = 3'b010;
        @(negedge clk); check("single_rdy", 64'(req_rdy), 64'(3'b010));
        @(posedge clk); #1; req_vld = '0;
        @(negedge clk);
        check("single_xvld", 64'(ix_vld), 64'(1));
        check("single_x", 64'(ix), 64'(144));
        check("single_infl", 64'(infl), 64'(1));
        repeat (4) @(negedge clk);
        check("single_early", 64'(rsp_vld), 64'(0));
        @(negedge clk);
        check("single_rspvld", 64'(rsp_vld), 64'(3'b010));
        check("single_rspy", 64'(rsp_y), 64'(12));
        check("single_infl0", 64'(infl), 64'(0));
        @(negedge clk); check("single_pulse", 64'(rsp_vld), 64'(0));

        // Fairness after a gap: ptr wraps to 0 after serving requester 2.
        @(posedge clk); #1; req_x[95:64] = 32'd25; req_vld = 3'b100;
        @(negedge clk); check("fair_r2", 64'(req_rdy), 64'(3'b100));
        @(posedge clk); #1; req_x[31:0] = 32'd49; req_x[63:32] = 32'd64; req_vld = 3'b011;
        @(negedge clk); check("fair_wrap", 64'(req_rdy), 64'(3'b001));
        @(posedge clk); #1; req_vld = 3'b010;
        @(negedge clk); check("fair_next", 64'(req_rdy), 64'(3'b010));
        @(posedge clk); #1; req_vld = '0;
        repeat (10) @(negedge clk);
        check("fair_drain", 64'(infl), 64'(0));

        // Contention: all three valid; ptr sits at 2 after the previous grant to 1.
        @(posedge clk); #1; req_x = {32'd9, 32'd4, 32'd1}; req_vld = 3'b111;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("cont_gnt", 64'(req_rdy), 64'(3'(1) << ((2 + i) % 3)));
            check("cont_infl", 64'(infl), 64'((i < 6) ? i : 5));
            if (i >= 6) check("cont_b2b", 64'(rsp_vld != '0), 64'(1));
        end
        @(posedge clk); #1; req_vld = '0;
        repeat (10) @(negedge clk);
        check("cont_drain_sb", 64'(sb1.size()), 64'(0));
        check("cont_drain_infl", 64'(infl), 64'(0));

        // Spurious result with nothing outstanding.
        @(posedge clk); #1; inj_vld = 1'b1; inj_y = 16'd77;
        @(posedge clk); #1; inj_vld = 1'b0;
        @(negedge clk);
        check("spur_rspvld", 64'(rsp_vld), 64'(0));
        check("spur_err", 64'(err), 64'(1));
        repeat (3) @(negedge clk);
        check("spur_err_held", 64'(err), 64'(1));
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk); check("spur_err_clr", 64'(err), 64'(0));

        // Reset with five requests outstanding.
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1; req_x[31:0] = mid_x[k]; req_vld = 3'b001;
            @(negedge clk); check("mid_rdy", 64'(req_rdy), 64'(3'b001));
        end
        @(posedge clk); #1; req_vld = '0; rst = 1'b1;
        @(negedge clk);
        check("mid_infl5", 64'(infl), 64'(5));
        check("mid_rdy_rst", 64'(req_rdy), 64'(0));
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_reset");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1; req_x[95:64] = post_x[k]; req_vld = 3'b100;
            @(negedge clk); check("post_rdy", 64'(req_rdy), 64'(3'b100));
        end
        @(posedge clk); #1; req_vld = '0;
        repeat (10) @(negedge clk);
        check("post_drain_sb", 64'(sb1.size()), 64'(0));
        check("post_infl", 64'(infl), 64'(0));
        check("post_err", 64'(err), 64'(0));

        // Credit limit on the MAX_INFLIGHT=2 instance.
        nxt = 2;
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) begin
            req_x2[i*32 +: 32] = 32'(nxt * nxt);
            nxt++;
        end
        req_vld2 = 3'b111;
        acc_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            check("credit_max", 64'(infl2 <= 2'd2), 64'(1));
            if (infl2 == 2'd2) check("credit_rdy", 64'(req_rdy2), 64'(0));
            acc = req_vld2 & req_rdy2;
            if (c >= 12 && c < 48) acc_cnt += $countones(acc);
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) begin
                    req_x2[i*32 +: 32] = 32'(nxt * nxt);
                    nxt++;
                end
            end
        end
        check("credit_tput", 64'(acc_cnt), 64'(12));
        req_vld2 = '0;
        repeat (12) @(negedge clk);
        check("credit_drain_sb", 64'(sb2.size()), 64'(0));
        check("credit_infl", 64'(infl2), 64'(0));
        check("credit_err", 64'(err2), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
